// File: rtl/bcd2bin_seq.sv
`default_nettype none
// ============================================================================
// Module   : bcd2bin_seq
// Brief    : Iterative BCD-to-binary converter (reverse double-dabble) with a
//            start/busy/done handshake. Optional invalid-digit checking is
//            enabled by defining BCD2BIN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bcd2bin_seq #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int c_BCD_W = 4 * DIGITS;
    localparam int c_SR_W  = c_BCD_W + BIN_W;
    localparam int c_CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(BIN_W - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_SR_W-1:0]    r_sr;
    logic [c_SR_W-1:0]    w_sr_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic                 r_busy;
    logic                 w_busy_nxt;
    logic                 r_done;
    logic                 w_done_nxt;
    logic [BIN_W-1:0]     r_bin;
    logic [BIN_W-1:0]     w_bin_nxt;
    logic [c_SR_W-1:0]    w_shift;
    logic [c_SR_W-1:0]    w_corr;
    logic                 w_load;

    // Shift right, then fix every BCD digit independently (no inter-digit carry)
    assign w_shift = r_sr >> 1;

    always_comb begin
        w_corr = w_shift;
        for (int d = 0; d < DIGITS; d++) begin
            if (w_shift[BIN_W + 4*d +: 4] >= 4'd8) begin
                w_corr[BIN_W + 4*d +: 4] = w_shift[BIN_W + 4*d +: 4] - 4'd3;
            end
        end
    end

`ifdef BCD2BIN_CHECK_EN
    logic                 r_err;
    logic                 w_err_nxt;
    logic [DIGITS-1:0]    w_nib_bad;
    logic                 w_invalid;

    for (genvar d = 0; d < DIGITS; d++) begin : g_nib_chk
        assign w_nib_bad[d] = (bcd_in[4*d +: 4] > 4'd9);
    end

    assign w_invalid = |w_nib_bad;
    assign w_load    = start & ~w_invalid;
`else
    assign w_load    = start;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_bin_nxt   = r_bin;
`ifdef BCD2BIN_CHECK_EN
        w_err_nxt   = r_err;
`endif
        case (r_state)
            IDLE: begin
                if (w_load) begin
                    w_sr_nxt    = {bcd_in, {BIN_W{1'b0}}};
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = SHIFT;
                end
`ifdef BCD2BIN_CHECK_EN
                // Invalid operand: report immediately, never enter SHIFT
                if (start && w_invalid) begin
                    w_err_nxt  = 1'b1;
                    w_bin_nxt  = '0;
                    w_done_nxt = 1'b1;
                end
`endif
            end
            SHIFT: begin
                w_sr_nxt  = w_corr;
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == c_LAST) begin
                    w_bin_nxt   = w_corr[BIN_W-1:0];
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
`ifdef BCD2BIN_CHECK_EN
                    w_err_nxt   = 1'b0;
`endif
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bin   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_bin   <= w_bin_nxt;
        end
    end

`ifdef BCD2BIN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_nxt;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign busy    = r_busy;
    assign done    = r_done;
    assign bin_out = r_bin;

endmodule
`default_nettype wire

// File: tb/tb_bcd2bin_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd2bin_seq
// Brief    : Scoreboard bench for bcd2bin_seq: directed operands, queued
//            expectations, independent done monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd2bin_seq;

    localparam int DIGITS = 2;
    localparam int BIN_W  = 7;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [7:0]       bcd_in;
    logic             busy;
    logic             done;
    logic [BIN_W-1:0] bin_out;
    logic             err;

    int errors    = 0;
    int checks    = 0;
    int done_cnt  = 0;

    logic [BIN_W:0] sb_q[$];   // {err, bin}

    bcd2bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation
    always @(posedge clk) begin
        #1;
        if (rst_n && done === 1'b1) begin
            logic [BIN_W:0] e;
            done_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got bin_out=%0d with empty scoreboard", bin_out);
            end else begin
                e = sb_q.pop_front();
                check("bin_out", int'(bin_out), int'(e[BIN_W-1:0]));
                check("err", int'(err), int'(e[BIN_W]));
            end
        end
    end

    function automatic logic [7:0] enc(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic issue(input logic [7:0] v, input int exp_bin, input bit exp_err, input bit push);
        @(negedge clk);
        bcd_in = v;
        start  = 1'b1;
        if (push) sb_q.push_back({exp_err, 7'(exp_bin)});
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Called at the negedge after the capture edge; returns once done is seen
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy === 1'b1) bcnt++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done within %0d cycles, required one", lat);
        end
    endtask

    initial begin
        int lat, bcnt, dc, idx, g;
        start  = 1'b0;
        bcd_in = 8'h00;
        rst_n  = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_bin", int'(bin_out), 0);
        check("rst_err", int'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Largest valid operand: latency and busy length
        issue(8'h99, 99, 1'b0, 1'b1);
        wait_done(lat, bcnt);
        check("lat_99", lat, BIN_W);
        check("busy_99", bcnt, BIN_W);

        // Back-to-back sweep of every valid code with start held high
        @(negedge clk);
        start  = 1'b1;
        bcd_in = enc(0);
        sb_q.push_back({1'b0, 7'd0});
        idx = 1;
        g   = 0;
        while (idx < 100 && g < 3000) begin
            @(negedge clk);
            g++;
            if (done === 1'b1) begin
                bcd_in = enc(idx);
                sb_q.push_back({1'b0, 7'(idx)});
                idx++;
            end
        end
        if (idx < 100) begin
            checks++;
            errors++;
            $display("FAIL sweep_timeout: got %0d requests issued, required 100", idx);
        end
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bcnt);
        check("sweep_drained", sb_q.size(), 0);

        // Start during busy is ignored
        dc = done_cnt;
        issue(8'h42, 42, 1'b0, 1'b1);
        @(negedge clk);
        bcd_in = 8'h17;
        start  = 1'b1;
        repeat (2) @(negedge clk);
        start  = 1'b0;
        wait_done(lat, bcnt);
        repeat (15) @(posedge clk);
        #1;
        check("ignored_done_cnt", done_cnt, dc + 1);
        check("ignored_bin", int'(bin_out), 42);

        // Reset mid-conversion
        dc = done_cnt;
        issue(8'h63, 63, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_bin", int'(bin_out), 0);
        check("abort_no_done", done_cnt, dc);
        @(negedge clk);
        rst_n = 1'b1;
        issue(8'h05, 5, 1'b0, 1'b1);
        wait_done(lat, bcnt);
        check("lat_05", lat, BIN_W);

        // Zero operand, then idle hold
        issue(8'h00, 0, 1'b0, 1'b1);
        wait_done(lat, bcnt);
        check("lat_00", lat, BIN_W);
        issue(8'h58, 58, 1'b0, 1'b1);
        wait_done(lat, bcnt);
        check("busy_58", bcnt, BIN_W);
        dc = done_cnt;
        repeat (20) @(posedge clk);
        #1;
        check("idle_no_done", done_cnt, dc);
        check("idle_hold_bin", int'(bin_out), 58);

`ifdef BCD2BIN_CHECK_EN
        issue(8'h3A, 0, 1'b1, 1'b1);
        check("inv_done_next", int'(done), 1);
        check("inv_busy", int'(busy), 0);
        issue(8'h21, 21, 1'b0, 1'b1);
        wait_done(lat, bcnt);
        check("lat_21", lat, BIN_W);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
